// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline interlock.
//   state_e  : interlock FSM state
//   slot_t   : shadow copy of one in-flight instruction
//   FWD_*    : EX operand forward-select encodings
//   R_PC     : register number of the PC; never forwarded, never a hazard source
package pipe_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       is_load;
    logic [3:0] rd;
    logic [3:0] rn;
    logic [3:0] rm;
    logic       use_rn;
    logic       use_rm;
    logic       use_rd;
  } slot_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [3:0] R_PC = 4'd15;

  // True when the slot will write register r and is eligible to forward/hazard.
  function automatic logic slot_writes(slot_t s, logic [3:0] r);
    return s.valid && s.reg_write && (s.rd != R_PC) && (s.rd == r);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forward priority mux for the EX stage.
//   src_used_i : the EX instruction reads this operand
//   src_i      : register number of the operand
//   mem_i      : shadow slot currently in MEM
//   wb_i       : shadow slot currently in WB
//   sel_o      : FWD_MEM, FWD_WB or FWD_RF
module fwd_select
  import pipe_pkg::*;
(
  input  logic       src_used_i,
  input  logic [3:0] src_i,
  input  slot_t      mem_i,
  input  slot_t      wb_i,
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (src_used_i) begin
      // A load in MEM has no data yet; only its WB copy may forward.
      if (slot_writes(mem_i, src_i) && !mem_i.is_load) begin
        sel_o = FWD_MEM;
      end else if (slot_writes(wb_i, src_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

  logic unused_slot_fields;
  assign unused_slot_fields = ^{mem_i.rn, mem_i.rm, mem_i.use_rn, mem_i.use_rm, mem_i.use_rd,
                                wb_i.is_load, wb_i.rn, wb_i.rm, wb_i.use_rn, wb_i.use_rm,
                                wb_i.use_rd};

endmodule

// File: rtl/pipeline_interlock.sv
// Hazard / back-pressure controller for the five-stage pipeline.
// Tracks in-flight destinations in EX/MEM/WB shadow slots and drives:
//   pc_enable, if_id_enable, if_id_flush, cu_nop_select : hold/flush controls upstream
//   fwd_a, fwd_b, fwd_s : EX forward selects for Rn, Rm, store data
//   stall_count, flush_count : saturating debug counters
// Inputs: id_* describe the instruction in IF/ID, ex_branch_taken is PCSrc from EX.
module pipeline_interlock
  import pipe_pkg::*;
#(
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [3:0]       id_rn,
  input  logic [3:0]       id_rm,
  input  logic [3:0]       id_rd,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             id_uses_rd,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             cu_nop_select,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_s,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] StallInit = 2'(LOAD_STALL - 1);

  state_e             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  slot_t              ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  slot_t              id_slot;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic               hz;

  always_comb begin
    id_slot.valid     = id_valid;
    id_slot.reg_write = id_reg_write;
    id_slot.is_load   = id_is_load;
    id_slot.rd        = id_rd;
    id_slot.rn        = id_rn;
    id_slot.rm        = id_rm;
    id_slot.use_rn    = id_uses_rn;
    id_slot.use_rm    = id_uses_rm;
    id_slot.use_rd    = id_uses_rd;
  end

  // Load-use hazard against the EX slot.
  always_comb begin
    hz = id_valid && ex_q.valid && ex_q.is_load && ex_q.reg_write && (ex_q.rd != R_PC) &&
         ((id_uses_rn && (id_rn == ex_q.rd)) ||
          (id_uses_rm && (id_rm == ex_q.rd)) ||
          (id_uses_rd && (id_rd == ex_q.rd)));
  end

  // Hold/flush outputs and next state. hz is only consulted in RUN, so it is
  // masked in FLUSH (ID holds a NOP) and superseded by a taken branch.
  always_comb begin
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    if_id_flush   = 1'b0;
    cu_nop_select = 1'b0;
    state_d       = state_q;
    cnt_d         = cnt_q;
    unique case (state_q)
      StRun: begin
        if (ex_branch_taken) begin
          if_id_flush   = 1'b1;
          cu_nop_select = 1'b1;
          state_d       = StFlush;
        end else if (hz) begin
          pc_enable     = 1'b0;
          if_id_enable  = 1'b0;
          cu_nop_select = 1'b1;
          cnt_d         = StallInit;
          state_d       = (LOAD_STALL > 1) ? StStall : StRun;
        end
      end
      StStall: begin
        if (ex_branch_taken) begin
          if_id_flush   = 1'b1;
          cu_nop_select = 1'b1;
          state_d       = StFlush;
        end else begin
          pc_enable     = 1'b0;
          if_id_enable  = 1'b0;
          cu_nop_select = 1'b1;
          cnt_d         = cnt_q - 2'd1;
          // Last stall cycle is the one that counts down to zero.
          if (cnt_q <= 2'd1) begin
            state_d = StRun;
          end
        end
      end
      StFlush: begin
        state_d = StRun;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_comb begin
    ex_d  = cu_nop_select ? '0 : id_slot;
    mem_d = ex_q;
    wb_d  = mem_q;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_enable && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (if_id_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

  fwd_select u_fwd_a (
    .src_used_i (ex_q.valid && ex_q.use_rn),
    .src_i      (ex_q.rn),
    .mem_i      (mem_q),
    .wb_i       (wb_q),
    .sel_o      (fwd_a)
  );

  fwd_select u_fwd_b (
    .src_used_i (ex_q.valid && ex_q.use_rm),
    .src_i      (ex_q.rm),
    .mem_i      (mem_q),
    .wb_i       (wb_q),
    .sel_o      (fwd_b)
  );

  fwd_select u_fwd_s (
    .src_used_i (ex_q.valid && ex_q.use_rd),
    .src_i      (ex_q.rd),
    .mem_i      (mem_q),
    .wb_i       (wb_q),
    .sel_o      (fwd_s)
  );

endmodule
